logic_exec_unit: RTL and testbench

- Parametrised logical execute unit with its own general-purpose register file (GPR).
- Accepts one decoded instruction per valid/ready handshake and reads its operands from the GPR or an immediate.
- Executes single-cycle logical ops and multi-cycle shift/rotate ops (one bit per cycle), then writes the result back to the GPR.
- Sits between the instruction decoder and the processor's writeback/flag logic; adds width/depth generality and sequential shift modes to the existing single-cycle logical unit.

---
 rtl/logic_exec_unit.sv | 180 ++++++++++++++++++
 tb/tb_logic_exec_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/logic_exec_unit.sv
// Logical execute unit with a private GPR file: single-cycle logic ops plus
// bit-serial shift/rotate ops, results written back and flagged.
module logic_exec_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 32,
  parameter int unsigned IMM_W = 16,
  localparam int unsigned AW   = $clog2(NREG),
  localparam int unsigned SW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic             in_imm_mode,
  input  logic [AW-1:0]    in_rdst,
  input  logic [AW-1:0]    in_rsrc1,
  input  logic [AW-1:0]    in_rsrc2,
  input  logic [IMM_W-1:0] in_imm,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             sign,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;
  typedef enum logic [4:0] {
    OP_MOV  = 5'd1,  OP_OR  = 5'd5,  OP_AND = 5'd6,  OP_XOR = 5'd7,
    OP_XNOR = 5'd8,  OP_NAND = 5'd9, OP_NOR = 5'd10, OP_NOT = 5'd11,
    OP_SHL  = 5'd12, OP_SHR = 5'd13, OP_ROL = 5'd14, OP_ROR = 5'd15
  } op_t;

  state_t            r_state, w_next;
  logic [WIDTH-1:0]  r_gpr [NREG];
  logic [4:0]        r_op;
  logic              r_imm_mode;
  logic [AW-1:0]     r_rdst, r_rsrc1, r_rsrc2;
  logic [IMM_W-1:0]  r_imm;
  logic [WIDTH-1:0]  r_work;
  logic [SW-1:0]     r_cnt;
  logic              r_done, r_err, r_zero, r_sign;
  logic [WIDTH-1:0]  r_result;

  logic [WIDTH-1:0]  w_a, w_b, w_logic, w_shifted, w_wdata;
  logic [SW-1:0]     w_amt;
  logic              w_accept, w_we, w_done, w_err, w_load;

  assign in_ready = (r_state == IDLE);
  assign w_accept = in_valid && in_ready;
  assign done     = r_done;
  assign err      = r_err;
  assign result   = r_result;
  assign zero     = r_zero;
  assign sign     = r_sign;
  assign dbg_data = r_gpr[dbg_addr];

  // Operands are fetched in EXEC from the latched addresses, not at accept.
  assign w_a   = r_gpr[r_rsrc1];
  assign w_b   = r_imm_mode ? WIDTH'(r_imm) : r_gpr[r_rsrc2];
  assign w_amt = w_b[SW-1:0];

  always_comb begin
    w_logic = '0;
    case (op_t'(r_op))
      OP_MOV:  w_logic = w_b;
      OP_OR:   w_logic = w_a | w_b;
      OP_AND:  w_logic = w_a & w_b;
      OP_XOR:  w_logic = w_a ^ w_b;
      OP_XNOR: w_logic = ~(w_a ^ w_b);
      OP_NAND: w_logic = ~(w_a & w_b);
      OP_NOR:  w_logic = ~(w_a | w_b);
      OP_NOT:  w_logic = ~w_a;
      default: w_logic = '0;
    endcase
  end

  always_comb begin
    w_shifted = r_work;
    case (op_t'(r_op))
      OP_SHL:  w_shifted = {r_work[WIDTH-2:0], 1'b0};
      OP_SHR:  w_shifted = {1'b0, r_work[WIDTH-1:1]};
      OP_ROL:  w_shifted = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
      OP_ROR:  w_shifted = {r_work[0], r_work[WIDTH-1:1]};
      default: w_shifted = r_work;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_wdata = w_logic;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = EXEC;
      EXEC: begin
        w_next = IDLE;
        case (op_t'(r_op))
          OP_MOV, OP_OR, OP_AND, OP_XOR, OP_XNOR, OP_NAND, OP_NOR, OP_NOT: begin
            w_we   = 1'b1;
            w_done = 1'b1;
          end
          OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
            if (w_amt == '0) begin
              w_we    = 1'b1;
              w_wdata = w_a;
              w_done  = 1'b1;
            end else begin
              w_load = 1'b1;
              w_next = SHIFT;
            end
          end
          default: begin
            w_done = 1'b1;
            w_err  = 1'b1;
          end
        endcase
      end
      SHIFT: begin
        if (r_cnt == SW'(1)) begin
          w_we    = 1'b1;
          w_wdata = w_shifted;
          w_done  = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      for (int unsigned i = 0; i < NREG; i++) r_gpr[i] <= '0;
      r_op       <= '0;
      r_imm_mode <= 1'b0;
      r_rdst     <= '0;
      r_rsrc1    <= '0;
      r_rsrc2    <= '0;
      r_imm      <= '0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_sign     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done;
      r_err   <= w_err;
      if (w_accept) begin
        r_op       <= in_op;
        r_imm_mode <= in_imm_mode;
        r_rdst     <= in_rdst;
        r_rsrc1    <= in_rsrc1;
        r_rsrc2    <= in_rsrc2;
        r_imm      <= in_imm;
      end
      if (w_load) begin
        r_work <= w_a;
        r_cnt  <= w_amt;
      end else if (r_state == SHIFT) begin
        r_work <= w_shifted;
        r_cnt  <= r_cnt - SW'(1);
      end
      if (w_we) begin
        r_gpr[r_rdst] <= w_wdata;
        r_result      <= w_wdata;
        r_zero        <= (w_wdata == '0);
        r_sign        <= w_wdata[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_logic_exec_unit.sv
// Directed bench for logic_exec_unit with hand-computed expectations.
module tb_logic_exec_unit;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic        in_imm_mode;
  logic [4:0]  in_rdst, in_rsrc1, in_rsrc2;
  logic [15:0] in_imm;
  logic        done, err, zero, sign;
  logic [15:0] result, dbg_data;
  logic [4:0]  dbg_addr;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  logic_exec_unit #(.WIDTH(16), .NREG(32), .IMM_W(16)) dut (
    .clk(clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm_mode(in_imm_mode), .in_rdst(in_rdst),
    .in_rsrc1(in_rsrc1), .in_rsrc2(in_rsrc2), .in_imm(in_imm),
    .done(done), .err(err), .result(result), .zero(zero), .sign(sign),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic gpr(input string tag, input logic [4:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #0;
    check(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  // Present one instruction and return just after its accept edge.
  task automatic issue(input logic [4:0] op, input logic im, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [15:0] imm);
    check("ready_before_issue", {31'h0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_imm_mode = im;
    in_rdst = rd; in_rsrc1 = rs1; in_rsrc2 = rs2; in_imm = imm;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic exec1(input logic [4:0] op, input logic im, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [15:0] imm);
    issue(op, im, rd, rs1, rs2, imm);
    tick();
  endtask

  initial begin
    sys_rst = 1'b1; in_valid = 1'b0; in_op = '0; in_imm_mode = 1'b0;
    in_rdst = '0; in_rsrc1 = '0; in_rsrc2 = '0; in_imm = '0; dbg_addr = '0;
    tick(); tick();
    sys_rst = 1'b0;

    check("rst_ready",  {31'h0, in_ready}, 32'd1);
    check("rst_done",   {31'h0, done}, 32'd0);
    check("rst_err",    {31'h0, err}, 32'd0);
    check("rst_result", {16'h0, result}, 32'h0);
    check("rst_zero",   {31'h0, zero}, 32'd0);
    check("rst_sign",   {31'h0, sign}, 32'd0);
    gpr("rst_gpr0", 5'd0, 16'h0);

    // MOV imm r7 <- 2
    exec1(5'd1, 1'b1, 5'd7, 5'd0, 5'd0, 16'd2);
    check("mov_done", {31'h0, done}, 32'd1);
    check("mov_result", {16'h0, result}, 32'h0002);
    gpr("mov_r7", 5'd7, 16'h0002);

    // ANDI r4 = r7 & 56 -> 0
    issue(5'd6, 1'b1, 5'd4, 5'd7, 5'd0, 16'd56);
    check("andi_exec_done", {31'h0, done}, 32'd0);
    tick();
    check("andi_done", {31'h0, done}, 32'd1);
    check("andi_err",  {31'h0, err}, 32'd0);
    check("andi_zero", {31'h0, zero}, 32'd1);
    check("andi_sign", {31'h0, sign}, 32'd0);
    gpr("andi_r4", 5'd4, 16'h0000);

    // XORI r4 = r7 ^ 56 -> 0x003A, then RAW read of r4 issued in the done cycle
    exec1(5'd7, 1'b1, 5'd4, 5'd7, 5'd0, 16'd56);
    check("xori_done", {31'h0, done}, 32'd1);
    check("xori_result", {16'h0, result}, 32'h003A);
    check("xori_zero", {31'h0, zero}, 32'd0);
    check("xori_ready_in_done", {31'h0, in_ready}, 32'd1);
    exec1(5'd1, 1'b0, 5'd6, 5'd0, 5'd4, 16'h0);
    check("raw_result", {16'h0, result}, 32'h003A);
    gpr("raw_r6", 5'd6, 16'h003A);

    // MOV r1 <- 1; ROR r2 = r1 by 1 -> 0x8000
    exec1(5'd1, 1'b1, 5'd1, 5'd0, 5'd0, 16'h0001);
    issue(5'd15, 1'b1, 5'd2, 5'd1, 5'd0, 16'd1);
    tick();
    check("ror_not_yet", {31'h0, done}, 32'd0);
    tick();
    check("ror_done", {31'h0, done}, 32'd1);
    check("ror_result", {16'h0, result}, 32'h8000);
    check("ror_sign", {31'h0, sign}, 32'd1);
    gpr("ror_r2", 5'd2, 16'h8000);

    // MOV r3 <- 3; SHL r5 = r3 by 4 -> 0x0030 at accept+5
    exec1(5'd1, 1'b1, 5'd3, 5'd0, 5'd0, 16'h0003);
    issue(5'd12, 1'b1, 5'd5, 5'd3, 5'd0, 16'd4);
    for (int i = 0; i < 5; i++) begin
      check("shl_busy_ready", {31'h0, in_ready}, 32'd0);
      check("shl_busy_done", {31'h0, done}, 32'd0);
      tick();
    end
    check("shl_done", {31'h0, done}, 32'd1);
    check("shl_result", {16'h0, result}, 32'h0030);
    gpr("shl_r5", 5'd5, 16'h0030);

    // SHL by 0 completes in one cycle with A
    exec1(5'd12, 1'b1, 5'd5, 5'd3, 5'd0, 16'd0);
    check("shl0_done", {31'h0, done}, 32'd1);
    check("shl0_result", {16'h0, result}, 32'h0003);

    // NOT / NAND / XNOR spot checks
    exec1(5'd11, 1'b0, 5'd10, 5'd4, 5'd0, 16'h0);
    check("not_result", {16'h0, result}, 32'hFFC5);
    exec1(5'd9, 1'b1, 5'd11, 5'd10, 5'd0, 16'h00FF);
    check("nand_result", {16'h0, result}, 32'hFF3A);
    exec1(5'd8, 1'b0, 5'd12, 5'd4, 5'd10, 16'h0);
    check("xnor_result", {16'h0, result}, 32'h0000);
    check("xnor_zero", {31'h0, zero}, 32'd1);

    // Illegal op: error pulse, no state change
    exec1(5'd1, 1'b1, 5'd9, 5'd0, 5'd0, 16'h00FF);
    exec1(5'd31, 1'b1, 5'd9, 5'd9, 5'd0, 16'h1234);
    check("ill_done", {31'h0, done}, 32'd1);
    check("ill_err", {31'h0, err}, 32'd1);
    check("ill_result", {16'h0, result}, 32'h00FF);
    check("ill_zero", {31'h0, zero}, 32'd0);
    gpr("ill_r9", 5'd9, 16'h00FF);
    tick();
    check("ill_done_clear", {31'h0, done}, 32'd0);
    check("ill_err_clear", {31'h0, err}, 32'd0);

    // SHR by 8 aborted by reset sampled 3 cycles after accept
    issue(5'd13, 1'b1, 5'd8, 5'd9, 5'd0, 16'd8);
    tick(); tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("abort_done", {31'h0, done}, 32'd0);
    check("abort_ready", {31'h0, in_ready}, 32'd1);
    check("abort_result", {16'h0, result}, 32'h0);
    check("abort_sign", {31'h0, sign}, 32'd0);
    gpr("abort_r9", 5'd9, 16'h0);
    gpr("abort_r3", 5'd3, 16'h0);
    gpr("abort_r8", 5'd8, 16'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort_no_done", {31'h0, done}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
